data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4: maximum consecutive granted beats for one locked owner (legal range 1..15).
REQ-002 Parameter DEPTH, default 16384: number of 32-bit words in the attached data memory.
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on posedge clock.
REQ-005 a_req / b_req  input  1 each  requester A (core LSU) / B (DMA/debug) access request.
REQ-006 a_lock / b_lock  input  1 each  request to keep ownership for the next beat.
REQ-007 a_we / b_we  input  1 each  1 = write, 0 = read.
REQ-008 a_addr / b_addr  input  32 each  byte address.
REQ-009 a_wdata / b_wdata  input  32 each  write data.
REQ-010 a_gnt / b_gnt  output  1 each  combinational; access issued to memory this cycle.
REQ-011 a_rvalid / b_rvalid  output  1 each  registered; response for the beat granted in the previous cycle.
REQ-012 a_rdata / b_rdata  output  32 each  registered read data.
REQ-013 a_err / b_err  output  1 each  registered; response is an error.
REQ-014 mem_writeEn  output  1  memory write enable.
REQ-015 mem_address  output  32  byte address to memory.
REQ-016 mem_write_data  output  32  memory write data.
REQ-017 mem_read_data  input  32  combinational read data from memory at mem_address.

Function
REQ-018 States: IDLE, OWN_A, OWN_B; plus last_grant (A/B) and 4-bit burst_cnt.
REQ-019 Selection each cycle: in OWN_X with x_req=1, X is granted; otherwise, if both request, grant the requester not equal to last_grant; if one requests, grant it; if none, no grant.
REQ-020 At most one of a_gnt/b_gnt SHALL be 1 in any cycle; gnt SHALL never assert without the matching req.
REQ-021 Granted beat drives mem_address/mem_write_data from the winner; mem_writeEn = winner_we AND beat legal; with no grant mem_writeEn=0, mem_address=0, mem_write_data=0.
REQ-022 Beat illegal if addr[1:0]!=0 or (addr>>2)>=DEPTH; illegal beat SHALL NOT write.
REQ-023 Response latency exactly 1 cycle: cycle after a grant, x_rvalid=1 for one cycle; x_rdata=mem_read_data captured at the grant (reads; writes give 0); x_err=1 and x_rdata=0 for illegal beats.
REQ-024 With no grant in the previous cycle, both rvalid=0 and err=0; rdata holds its last value.
REQ-025 After granted beat by X: if x_lock=1 and burst_cnt+1<MAX_BURST, next state OWN_X and burst_cnt+1; otherwise next state IDLE, burst_cnt=0, last_grant=X.
REQ-026 In OWN_X with x_req=0: ownership dropped same cycle; selection per REQ-019 from IDLE rules; burst_cnt=0 and last_grant=X at end of cycle.
REQ-027 After burst limit, owner re-requesting while other idle SHALL be re-granted next cycle (no dead cycle).
REQ-028 Requester holds req/we/addr/wdata stable until its gnt; arbiter needs no buffering.

Reset
REQ-029 reset=0 at posedge: state=IDLE, last_grant=B, burst_cnt=0, all rvalid/err=0, all rdata=0.
REQ-030 While reset=0, a_gnt=b_gnt=0 and mem_writeEn=0 regardless of requests; reset mid-burst aborts ownership, beat in flight produces no response.

Verification
REQ-031 Single A read addr 0x10, mem word 4 = 0xDEADBEEF -> a_gnt same cycle; next cycle a_rvalid=1, a_rdata=0xDEADBEEF, a_err=0.
REQ-032 A and B request together out of reset, no lock -> A, B, A, B alternate grants each cycle.
REQ-033 A locked continuously, B requesting, MAX_BURST=4 -> A granted 4 beats, then B 1 beat, then A 4 beats.
REQ-034 B write addr 0x6 -> b_gnt=1, mem_writeEn=0; next cycle b_rvalid=1, b_err=1, b_rdata=0; addr 0x10000 (word 16384) same result.
REQ-035 Reset asserted during A's 2nd locked beat -> gnt/mem_writeEn 0 that cycle, no a_rvalid next cycle; after release with both requesting, A granted first.
REQ-036 A locked beat then a_req drops with B waiting -> B granted in the cycle a_req drops.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter in front of a single-port 32-bit data memory.
// Requester A is the core load/store unit, requester B is the DMA/debug
// port. Grants are combinational, responses come back one cycle later.
// A requester may lock ownership for up to MAX_BURST consecutive beats,
// otherwise contention is resolved round-robin on the last granted side.

module data_mem_arbiter #(
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned DEPTH     = 16384
) (
   input  logic        clock,
   input  logic        reset,

   input  logic        a_req,
   input  logic        a_lock,
   input  logic        a_we,
   input  logic [31:0] a_addr,
   input  logic [31:0] a_wdata,
   output logic        a_gnt,
   output logic        a_rvalid,
   output logic [31:0] a_rdata,
   output logic        a_err,

   input  logic        b_req,
   input  logic        b_lock,
   input  logic        b_we,
   input  logic [31:0] b_addr,
   input  logic [31:0] b_wdata,
   output logic        b_gnt,
   output logic        b_rvalid,
   output logic [31:0] b_rdata,
   output logic        b_err,

   output logic        mem_writeEn,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   localparam logic [31:0] DEPTH_W    = 32'(DEPTH);
   localparam logic [4:0]  MAX_BURST_W = 5'(MAX_BURST);

   typedef enum logic [1:0] {
      IDLE,
      OWN_A,
      OWN_B
   } state_t;

   state_t      state;
   logic        last_grant;
   logic [3:0]  burst_cnt;

   logic        any_gnt;
   logic        win_we;
   logic        win_lock;
   logic [31:0] win_addr;
   logic [31:0] win_wdata;
   logic        beat_legal;
   logic        owner_dropped;
   logic        win_continues;
   logic [4:0]  cnt_next;
   logic        can_hold;

   // Pick this cycle's winner: a live owner keeps the port, otherwise the
   // side that did not win last time gets priority; nothing is granted in reset.
   always_comb begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
      if (reset) begin
         if (state == OWN_A && a_req) begin
            a_gnt = 1'b1;
         end else if (state == OWN_B && b_req) begin
            b_gnt = 1'b1;
         end else if (a_req && b_req) begin
            if (last_grant) begin
               a_gnt = 1'b1;
            end else begin
               b_gnt = 1'b1;
            end
         end else if (a_req) begin
            a_gnt = 1'b1;
         end else if (b_req) begin
            b_gnt = 1'b1;
         end
      end
   end

   // Route the winner onto the memory port, check its beat for alignment and
   // range, and work out whether its lock can carry ownership into next cycle.
   always_comb begin
      any_gnt        = a_gnt | b_gnt;
      win_we         = b_gnt ? b_we    : a_we;
      win_lock       = b_gnt ? b_lock  : a_lock;
      win_addr       = b_gnt ? b_addr  : a_addr;
      win_wdata      = b_gnt ? b_wdata : a_wdata;
      beat_legal     = (win_addr[1:0] == 2'b00) && ({2'b00, win_addr[31:2]} < DEPTH_W);

      mem_writeEn    = any_gnt & win_we & beat_legal;
      mem_address    = any_gnt ? win_addr  : 32'h0;
      mem_write_data = any_gnt ? win_wdata : 32'h0;

      owner_dropped  = (state == OWN_A && !a_req) || (state == OWN_B && !b_req);
      win_continues  = (a_gnt && state == OWN_A) || (b_gnt && state == OWN_B);
      cnt_next       = (win_continues ? {1'b0, burst_cnt} : 5'd0) + 5'd1;
      can_hold       = win_lock && (cnt_next < MAX_BURST_W);
   end

   // Ownership/burst bookkeeping plus the one-cycle-late response registers;
   // reset clears everything and discards any beat that was in flight.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         burst_cnt  <= 4'd0;
         a_rvalid   <= 1'b0;
         a_err      <= 1'b0;
         a_rdata    <= 32'h0;
         b_rvalid   <= 1'b0;
         b_err      <= 1'b0;
         b_rdata    <= 32'h0;
      end else begin
         if (any_gnt) begin
            if (can_hold) begin
               state     <= a_gnt ? OWN_A : OWN_B;
               burst_cnt <= cnt_next[3:0];
               if (owner_dropped) begin
                  last_grant <= (state == OWN_B);
               end
            end else begin
               state      <= IDLE;
               burst_cnt  <= 4'd0;
               last_grant <= b_gnt;
            end
         end else if (state != IDLE) begin
            state      <= IDLE;
            burst_cnt  <= 4'd0;
            last_grant <= (state == OWN_B);
         end

         a_rvalid <= a_gnt;
         a_err    <= a_gnt & ~beat_legal;
         if (a_gnt) begin
            a_rdata <= (beat_legal && !win_we) ? mem_read_data : 32'h0;
         end

         b_rvalid <= b_gnt;
         b_err    <= b_gnt & ~beat_legal;
         if (b_gnt) begin
            b_rdata <= (beat_legal && !win_we) ? mem_read_data : 32'h0;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a behavioural memory sits on the memory port,
// each scenario task drives requests and checks grants at the falling edge,
// and expected responses go to per-side queues checked by a response monitor.

module tb_data_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        a_req = 1'b0, a_lock = 1'b0, a_we = 1'b0;
   logic [31:0] a_addr = 32'h0, a_wdata = 32'h0;
   logic        b_req = 1'b0, b_lock = 1'b0, b_we = 1'b0;
   logic [31:0] b_addr = 32'h0, b_wdata = 32'h0;
   logic        a_gnt, a_rvalid, a_err;
   logic [31:0] a_rdata;
   logic        b_gnt, b_rvalid, b_err;
   logic [31:0] b_rdata;
   logic        mem_writeEn;
   logic [31:0] mem_address, mem_write_data, mem_read_data;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit mon_en   = 1'b0;

   typedef struct {
      int          due;
      logic [31:0] rdata;
      logic        err;
   } resp_t;

   resp_t qa[$];
   resp_t qb[$];
   logic  ev_a, ev_b;
   resp_t ea, eb;

   logic [31:0] mem     [0:16383];
   bit          written [0:16383];

   data_mem_arbiter #(.MAX_BURST(4), .DEPTH(16384)) dut (
      .clock(clock), .reset(reset),
      .a_req(a_req), .a_lock(a_lock), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
      .b_req(b_req), .b_lock(b_lock), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
      .mem_writeEn(mem_writeEn), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
   );

   always #5 clock = ~clock;

   // Initial memory contents are a fixed pattern; word 4 holds 0xDEADBEEF.
   function automatic logic [31:0] model_word(input logic [13:0] i);
      if (i == 14'd4) return 32'hDEADBEEF;
      return 32'h1000_0000 + ({18'b0, i} * 32'h0001_0003);
   endfunction

   // Behavioural memory: combinational read, write on the rising edge.
   assign mem_read_data = (mem_address < 32'h10000) ?
                          (written[mem_address[15:2]] ? mem[mem_address[15:2]]
                                                      : model_word(mem_address[15:2]))
                          : 32'h0;

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (mem_writeEn && mem_address < 32'h10000) begin
         mem[mem_address[15:2]]     <= mem_write_data;
         written[mem_address[15:2]] <= 1'b1;
      end
   end

   // Response monitor: each cycle rvalid must match whether a response is due.
   always @(negedge clock) begin
      if (mon_en) begin
         ev_a = (qa.size() > 0) && (qa[0].due == cyc);
         n_checks++;
         if (a_rvalid !== ev_a) begin
            n_fail++;
            $display("[TB] FAIL a_rvalid cyc %0d: got %b expected %b", cyc, a_rvalid, ev_a);
         end
         if (ev_a) begin
            ea = qa.pop_front();
            n_checks++;
            if (a_rdata !== ea.rdata) begin
               n_fail++;
               $display("[TB] FAIL a_rdata cyc %0d: got %h expected %h", cyc, a_rdata, ea.rdata);
            end
            n_checks++;
            if (a_err !== ea.err) begin
               n_fail++;
               $display("[TB] FAIL a_err cyc %0d: got %b expected %b", cyc, a_err, ea.err);
            end
         end else begin
            n_checks++;
            if (a_err !== 1'b0) begin
               n_fail++;
               $display("[TB] FAIL a_err_idle cyc %0d: got %b expected 0", cyc, a_err);
            end
         end

         ev_b = (qb.size() > 0) && (qb[0].due == cyc);
         n_checks++;
         if (b_rvalid !== ev_b) begin
            n_fail++;
            $display("[TB] FAIL b_rvalid cyc %0d: got %b expected %b", cyc, b_rvalid, ev_b);
         end
         if (ev_b) begin
            eb = qb.pop_front();
            n_checks++;
            if (b_rdata !== eb.rdata) begin
               n_fail++;
               $display("[TB] FAIL b_rdata cyc %0d: got %h expected %h", cyc, b_rdata, eb.rdata);
            end
            n_checks++;
            if (b_err !== eb.err) begin
               n_fail++;
               $display("[TB] FAIL b_err cyc %0d: got %b expected %b", cyc, b_err, eb.err);
            end
         end else begin
            n_checks++;
            if (b_err !== 1'b0) begin
               n_fail++;
               $display("[TB] FAIL b_err_idle cyc %0d: got %b expected 0", cyc, b_err);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      a_req = 1'b0; a_lock = 1'b0; a_we = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
      b_req = 1'b0; b_lock = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      mon_en = 1'b1;
      a_req = 1'b1; a_we = 1'b1; a_addr = 32'h10; a_wdata = 32'h1111_1111;
      b_req = 1'b1; b_we = 1'b1; b_addr = 32'h20; b_wdata = 32'h2222_2222;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         n_checks++;
         if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_gnt: got a=%b b=%b expected 0 0", a_gnt, b_gnt);
         end
         n_checks++;
         if (mem_writeEn !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_we: got %b expected 0", mem_writeEn);
         end
         n_checks++;
         if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_rdata: got a=%h b=%h expected 0 0", a_rdata, b_rdata);
         end
         tick();
      end
      idle_inputs();
      reset = 1'b1;
   endtask

   task automatic test_single_read();
      a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10;
      @(negedge clock);
      n_checks++;
      if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL single_gnt: got a=%b b=%b expected 1 0", a_gnt, b_gnt);
      end
      n_checks++;
      if (mem_address !== 32'h10 || mem_writeEn !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL single_port: got addr=%h we=%b expected 00000010 0", mem_address, mem_writeEn);
      end
      qa.push_back('{cyc + 1, 32'hDEADBEEF, 1'b0});
      tick();
      idle_inputs();
      @(negedge clock);
      n_checks++;
      if (a_gnt !== 1'b0 || mem_address !== 32'h0 || mem_write_data !== 32'h0) begin
         n_fail++;
         $display("[TB] FAIL idle_port: got gnt=%b addr=%h wdata=%h expected 0 0 0", a_gnt, mem_address, mem_write_data);
      end
      tick();
   endtask

   task automatic test_write_read_hold();
      a_req = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_wdata = 32'h1234_5678;
      @(negedge clock);
      n_checks++;
      if (a_gnt !== 1'b1 || mem_writeEn !== 1'b1 || mem_write_data !== 32'h1234_5678) begin
         n_fail++;
         $display("[TB] FAIL write_port: got gnt=%b we=%b wdata=%h expected 1 1 12345678", a_gnt, mem_writeEn, mem_write_data);
      end
      qa.push_back('{cyc + 1, 32'h0, 1'b0});
      tick();
      a_we = 1'b0;
      @(negedge clock);
      n_checks++;
      if (a_gnt !== 1'b1 || mem_writeEn !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL readback_gnt: got gnt=%b we=%b expected 1 0", a_gnt, mem_writeEn);
      end
      qa.push_back('{cyc + 1, 32'h1234_5678, 1'b0});
      tick();
      idle_inputs();
      tick();
      @(negedge clock);
      n_checks++;
      if (a_rdata !== 32'h1234_5678) begin
         n_fail++;
         $display("[TB] FAIL rdata_hold: got %h expected 12345678", a_rdata);
      end
      tick();
   endtask

   task automatic test_alternate();
      do_reset();
      a_req = 1'b1; a_addr = 32'h40;
      b_req = 1'b1; b_addr = 32'h80;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         n_checks++;
         if (a_gnt !== (i % 2 == 0) || b_gnt !== (i % 2 == 1)) begin
            n_fail++;
            $display("[TB] FAIL alternate_%0d: got a=%b b=%b expected %b %b", i, a_gnt, b_gnt, (i % 2 == 0), (i % 2 == 1));
         end
         if (i % 2 == 0) qa.push_back('{cyc + 1, model_word(14'd16), 1'b0});
         else            qb.push_back('{cyc + 1, model_word(14'd32), 1'b0});
         tick();
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_lock_burst();
      do_reset();
      a_req = 1'b1; a_lock = 1'b1; a_addr = 32'h40;
      b_req = 1'b1; b_addr = 32'h80;
      for (int i = 0; i < 9; i++) begin
         @(negedge clock);
         n_checks++;
         if (a_gnt !== (i != 4) || b_gnt !== (i == 4)) begin
            n_fail++;
            $display("[TB] FAIL burst_%0d: got a=%b b=%b expected %b %b", i, a_gnt, b_gnt, (i != 4), (i == 4));
         end
         if (i != 4) qa.push_back('{cyc + 1, model_word(14'd16), 1'b0});
         else        qb.push_back('{cyc + 1, model_word(14'd32), 1'b0});
         tick();
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_burst_regrant();
      do_reset();
      a_req = 1'b1; a_lock = 1'b1; a_addr = 32'h40;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         n_checks++;
         if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL regrant_%0d: got a=%b b=%b expected 1 0", i, a_gnt, b_gnt);
         end
         qa.push_back('{cyc + 1, model_word(14'd16), 1'b0});
         tick();
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_illegal();
      logic [31:0] bad_addr [2];
      bad_addr[0] = 32'h6;
      bad_addr[1] = 32'h10000;
      b_req = 1'b1; b_we = 1'b1; b_wdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 2; i++) begin
         b_addr = bad_addr[i];
         @(negedge clock);
         n_checks++;
         if (b_gnt !== 1'b1 || a_gnt !== 1'b0 || mem_writeEn !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL illegal_%0d: got b=%b a=%b we=%b expected 1 0 0", i, b_gnt, a_gnt, mem_writeEn);
         end
         qb.push_back('{cyc + 1, 32'h0, 1'b1});
         tick();
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      a_req = 1'b1; a_lock = 1'b1; a_we = 1'b1; a_addr = 32'h44; a_wdata = 32'hA5A5_A5A5;
      b_req = 1'b1; b_addr = 32'h80;
      @(negedge clock);
      n_checks++;
      if (a_gnt !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL midrst_first: got %b expected 1", a_gnt);
      end
      qa.push_back('{cyc + 1, 32'h0, 1'b0});
      tick();
      reset = 1'b0;
      @(negedge clock);
      n_checks++;
      if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || mem_writeEn !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL midrst_hold: got a=%b b=%b we=%b expected 0 0 0", a_gnt, b_gnt, mem_writeEn);
      end
      tick();
      reset = 1'b1;
      a_lock = 1'b0;
      @(negedge clock);
      n_checks++;
      if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL midrst_after: got a=%b b=%b expected 1 0", a_gnt, b_gnt);
      end
      qa.push_back('{cyc + 1, 32'h0, 1'b0});
      tick();
      a_req = 1'b0; a_we = 1'b0;
      @(negedge clock);
      n_checks++;
      if (b_gnt !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL midrst_b: got %b expected 1", b_gnt);
      end
      qb.push_back('{cyc + 1, model_word(14'd32), 1'b0});
      tick();
      idle_inputs();
      tick();
   endtask

   task automatic test_lock_drop();
      do_reset();
      a_req = 1'b1; a_lock = 1'b1; a_addr = 32'h40;
      b_req = 1'b1; b_addr = 32'h80;
      @(negedge clock);
      n_checks++;
      if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL drop_first: got a=%b b=%b expected 1 0", a_gnt, b_gnt);
      end
      qa.push_back('{cyc + 1, model_word(14'd16), 1'b0});
      tick();
      a_req = 1'b0; a_lock = 1'b0;
      @(negedge clock);
      n_checks++;
      if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL drop_b: got a=%b b=%b expected 0 1", a_gnt, b_gnt);
      end
      qb.push_back('{cyc + 1, model_word(14'd32), 1'b0});
      tick();
      idle_inputs();
      tick();
   endtask

   // Run every scenario in order, then confirm no response was left outstanding.
   initial begin
      test_reset();
      test_single_read();
      test_write_read_hold();
      test_alternate();
      test_lock_burst();
      test_burst_regrant();
      test_illegal();
      test_reset_mid_burst();
      test_lock_drop();
      tick();
      tick();
      n_checks++;
      if (qa.size() != 0 || qb.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL pending_responses: got a=%0d b=%0d expected 0 0", qa.size(), qb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
